// File: rtl/sdio_dat_ddr_serializer.sv
// sdio_dat_ddr_serializer: one SDIO data block onto one DAT line, two bits per clk (start, data MSB-first, CRC16, end)
//  crc16_2bit : combinational CRC16 (x^16+x^12+x^5+1) advance by two bits, b0 first
//  sdio_dat_ddr_serializer ports:
//   clk, rst           clock, synchronous active-high reset
//   start, blk_len     begin-block pulse and byte count (1..MAX_BLOCK), sampled in IDLE
//   i_data, i_valid    byte stream in; o_ready marks the cycle a byte is taken
//   sd_oe              DAT output enable
//   sd_bit0, sd_bit1   earlier / later bit of this clk's pair
//   busy, done         block in progress; 1-clk pulse after a complete block
//   underrun           1-clk pulse when a required byte was missing

module crc16_2bit (
   input  logic [15:0] crc,
   input  logic        b0,
   input  logic        b1,
   output logic [15:0] nxt
);
   logic [15:0] mid;
   always_comb begin
      mid = {crc[14:0], 1'b0} ^ ((crc[15] ^ b0) ? 16'h1021 : 16'h0000);
      nxt = {mid[14:0], 1'b0} ^ ((mid[15] ^ b1) ? 16'h1021 : 16'h0000);
   end
endmodule

module sdio_dat_ddr_serializer #(
   parameter int MAX_BLOCK = 2048,
   parameter int LEN_W     = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] blk_len,
   input  logic [7:0]       i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             sd_oe,
   output logic             sd_bit0,
   output logic             sd_bit1,
   output logic             busy,
   output logic             done,
   output logic             underrun
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_END} st_t;
   localparam logic [LEN_W:0] MAXL = (LEN_W + 1)'(MAX_BLOCK);
   st_t              st, st_n;
   logic [LEN_W-1:0] cnt;
   logic [1:0]       pc;
   logic [2:0]       k;
   logic [5:0]       sh;
   logic [15:0]      crc, crc_nxt, csh;
   logic             len_ok, load, oe_n, done_n, und_n;
   logic [1:0]       b_n;
   crc16_2bit u_crc (.crc(crc), .b0(sd_bit0), .b1(sd_bit1), .nxt(crc_nxt));
   assign len_ok  = blk_len != '0 && {1'b0, blk_len} <= MAXL;
   // cnt holds bytes remaining including the one on the wire; at 1 no further byte is fetched
   assign o_ready = st == S_START || (st == S_DATA && pc == 2'd3 && cnt != LEN_W'(1));
   assign load    = o_ready && i_valid;
   always_comb begin
      st_n = st;
      case (st)
         S_IDLE:  st_n = start && len_ok ? S_START : S_IDLE;
         S_START: st_n = i_valid ? S_DATA : S_IDLE;
         S_DATA:  st_n = pc != 2'd3 ? S_DATA : cnt == LEN_W'(1) ? S_CRC : i_valid ? S_DATA : S_IDLE;
         S_CRC:   st_n = k == 3'd7 ? S_END : S_CRC;
         default: st_n = S_IDLE;
      endcase
   end
   // next-cycle values of the registered outputs; the last DATA pair feeds crc_nxt straight into the first CRC pair
   always_comb begin
      oe_n   = st_n != S_IDLE;
      done_n = st == S_END;
      und_n  = o_ready && !i_valid;
      b_n    = st_n == S_START ? 2'b10 :
               st_n == S_DATA  ? (load ? i_data[7:6] : sh[5:4]) :
               st_n == S_CRC   ? (st == S_DATA ? crc_nxt[15:14] : csh[15:14]) : 2'b11;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= S_IDLE;
         sd_oe    <= 1'b0;
         sd_bit0  <= 1'b1;
         sd_bit1  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         underrun <= 1'b0;
         cnt      <= '0;
         pc       <= '0;
         k        <= '0;
         sh       <= '0;
         crc      <= '0;
         csh      <= '0;
      end else begin
         st       <= st_n;
         sd_oe    <= oe_n;
         busy     <= oe_n;
         {sd_bit0, sd_bit1} <= b_n;
         done     <= done_n;
         underrun <= und_n;
         cnt      <= (st == S_IDLE && start && len_ok) ? blk_len :
                     (st == S_DATA && load) ? cnt - LEN_W'(1) : cnt;
         pc       <= st == S_DATA ? pc + 2'd1 : 2'd0;
         k        <= st == S_CRC ? k + 3'd1 : 3'd0;
         sh       <= load ? i_data[5:0] : {sh[3:0], 2'b00};
         crc      <= st_n == S_IDLE ? 16'h0000 : st == S_DATA ? crc_nxt : crc;
         csh      <= st == S_DATA ? {crc_nxt[13:0], 2'b00} : {csh[13:0], 2'b00};
      end
   end
endmodule

// File: tb/tb_sdio_dat_ddr_serializer.sv
// tb_sdio_dat_ddr_serializer: randomized bench against a per-cycle behavioural model of the DAT serializer
module tb_sdio_dat_ddr_serializer;
   localparam int MAXB = 2048;
   logic clk = 0, rst = 1, start = 0, i_valid = 0;
   logic [11:0] blk_len = 0;
   logic [7:0]  i_data = 0;
   logic o_ready, sd_oe, sd_bit0, sd_bit1, busy, done, underrun;
   sdio_dat_ddr_serializer #(.MAX_BLOCK(MAXB), .LEN_W(12)) dut (
      .clk(clk), .rst(rst), .start(start), .blk_len(blk_len), .i_data(i_data), .i_valid(i_valid),
      .o_ready(o_ready), .sd_oe(sd_oe), .sd_bit0(sd_bit0), .sd_bit1(sd_bit1),
      .busy(busy), .done(done), .underrun(underrun));
   always #5 clk = ~clk;
   int n_cmp = 0, n_bad = 0;
   bit m_active = 0, p_done = 0, p_und = 0, chk_en = 0;
   int m_t = 0, m_n = 0;
   logic [7:0]  mb [0:MAXB-1];
   logic [15:0] m_crc = 0;
   int done_cnt = 0, und_cnt = 0, hs_cnt = 0, busy_cnt = 0;
   logic [27:0] stream = 0;
   int dm = 0, vm = 0, drop_t = -1;
   logic [7:0] fb = 0;
   function automatic logic [15:0] crc_of(input int n);
      logic [15:0] c = 0;
      for (int i = 0; i < n; i++)
         for (int b = 7; b >= 0; b--)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ mb[i][b]) ? 16'h1021 : 16'h0000);
      return c;
   endfunction
   // input driver: data pattern and valid behaviour set by the main sequence
   always @(posedge clk) begin
      #1;
      i_data  = dm != 0 ? 8'($urandom) : fb;
      i_valid = vm == 0 ? 1'b1 : vm == 1 ? ($urandom % 4 != 0) : !(m_active && m_t == drop_t);
   end
   // model: m_t counts cycles from the START cycle; compare then advance
   always @(negedge clk) begin
      logic [6:0] exp_v, act_v;
      logic [1:0] b;
      logic rdy;
      int i, p, j;
      if (chk_en) begin
         rdy = 0;
         b = 2'b11;
         if (m_active) begin
            if (m_t == 0) begin
               b = 2'b10;
               rdy = 1;
            end else if (m_t <= 4 * m_n) begin
               i = (m_t - 1) / 4;
               p = (m_t - 1) % 4;
               b = {mb[i][7-2*p], mb[i][6-2*p]};
               rdy = (p == 3) && (i < m_n - 1);
            end else if (m_t <= 4 * m_n + 8) begin
               j = m_t - 4 * m_n - 1;
               b = {m_crc[15-2*j], m_crc[14-2*j]};
            end
            exp_v = {1'b1, b, 1'b1, 2'b00, rdy};
         end else
            exp_v = {1'b0, 2'b11, 1'b0, p_done, p_und, 1'b0};
         act_v = {sd_oe, sd_bit0, sd_bit1, busy, done, underrun, o_ready};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL outputs t=%0d act{oe,b0,b1,busy,done,und,rdy}=%b exp=%b time=%0t", m_t, act_v, exp_v, $time);
         end
         if (busy) begin
            busy_cnt++;
            stream = {stream[25:0], sd_bit0, sd_bit1};
         end
         done_cnt += int'(done);
         und_cnt  += int'(underrun);
         hs_cnt   += int'(o_ready && i_valid);
         p_done = 0;
         p_und = 0;
         if (rst) m_active = 0;
         else if (m_active) begin
            if (rdy && !i_valid) begin
               m_active = 0;
               p_und = 1;
            end else begin
               if (rdy) mb[m_t == 0 ? 0 : (m_t - 1) / 4 + 1] = i_data;
               if (m_t == 4 * m_n) m_crc = crc_of(m_n);
               if (m_t == 4 * m_n + 9) begin
                  m_active = 0;
                  p_done = 1;
               end else m_t++;
            end
         end else if (start && blk_len >= 1 && blk_len <= MAXB) begin
            m_active = 1;
            m_t = 0;
            m_n = int'(blk_len);
         end
      end
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string nm, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", nm, got, got, want, want);
      end
   endtask
   task automatic run(input int n, input int dmi, input logic [7:0] fbi, input int vmi, input int dt, input int inj);
      dm = dmi; fb = fbi; vm = vmi; drop_t = dt;
      start = 1;
      blk_len = 12'(n);
      tick;
      start = 0;
      for (int k = 0; k < 4 * n + 30 && m_active; k++) begin
         if (k == inj) begin
            start = 1;
            blk_len = 12'd5;
         end
         tick;
         start = 0;
      end
      if (m_active) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout block n=%0d still active", n);
      end
      tick;
      tick;
   endtask
   initial begin
      int d0, b0, u0, h0;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1;
      check("reset_outputs", int'({sd_oe, sd_bit0, sd_bit1, busy, done, underrun, o_ready}), 7'b0110000);
      rst = 0;
      tick;
      d0 = done_cnt; b0 = busy_cnt;
      run(1, 0, 8'h01, 0, -1, -1);
      check("t1_busy", busy_cnt - b0, 14);
      check("t1_done", done_cnt - d0, 1);
      check("t1_crc_model", int'(m_crc), 16'h1021);
      check("t1_stream", int'(stream), 28'h8044087);
      d0 = done_cnt; b0 = busy_cnt;
      run(1, 0, 8'h00, 0, -1, -1);
      check("t2_busy", busy_cnt - b0, 14);
      check("t2_crc_model", int'(m_crc), 0);
      d0 = done_cnt; b0 = busy_cnt; h0 = hs_cnt;
      run(512, 0, 8'hFF, 0, -1, -1);
      check("t3_busy", busy_cnt - b0, 2058);
      check("t3_handshakes", hs_cnt - h0, 512);
      check("t3_crc_model", int'(m_crc), 16'h7FA1);
      check("t3_done", done_cnt - d0, 1);
      d0 = done_cnt; b0 = busy_cnt; u0 = und_cnt;
      run(4, 1, 8'h00, 2, 8, -1);
      check("t4_underrun", und_cnt - u0, 1);
      check("t4_no_done", done_cnt - d0, 0);
      check("t4_busy", busy_cnt - b0, 9);
      d0 = done_cnt;
      run(1, 0, 8'h01, 0, -1, -1);
      check("t4_recover_crc", int'(m_crc), 16'h1021);
      check("t4_recover_done", done_cnt - d0, 1);
      d0 = done_cnt; u0 = und_cnt;
      dm = 1; vm = 0;
      start = 1;
      blk_len = 12'd16;
      tick;
      start = 0;
      repeat (20) tick;
      rst = 1;
      tick;
      rst = 0;
      check("t5_rst_idle", int'({sd_oe, busy}), 0);
      repeat (3) tick;
      check("t5_rst_no_pulses", (done_cnt - d0) + (und_cnt - u0), 0);
      d0 = done_cnt; b0 = busy_cnt;
      run(2, 0, 8'hA5, 0, -1, 3);
      check("t5_start_while_busy", busy_cnt - b0, 18);
      check("t5_one_done", done_cnt - d0, 1);
      b0 = busy_cnt;
      start = 1;
      blk_len = 12'd0;
      tick;
      start = 0;
      repeat (3) tick;
      check("t5_len0_ignored", busy_cnt - b0, 0);
      d0 = done_cnt; b0 = busy_cnt;
      run(2048, 1, 8'h00, 0, -1, -1);
      check("t6_busy", busy_cnt - b0, 8202);
      check("t6_done", done_cnt - d0, 1);
      b0 = busy_cnt;
      start = 1;
      blk_len = 12'd2049;
      tick;
      start = 0;
      repeat (3) tick;
      check("t6_len2049_ignored", busy_cnt - b0, 0);
      for (int r = 0; r < 8; r++) run($urandom_range(1, 6), 1, 8'h00, 1, -1, -1);
      vm = 0;
      tick;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
